// File: rtl/pattern_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_counter
//  Purpose  : Reads NUM_BYTES bytes from a synchronous data memory and counts
//             occurrences of a PAT_W-bit pattern: windows inside a byte,
//             bytes holding at least one such window, and windows anywhere in
//             the MSB-first bit string (byte boundaries included).
//  Options  : define PATCNT_MASK_EN to add a pat_mask input (don't-care bits).
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_counter #(
    parameter int PAT_W     = 5,
    parameter int NUM_BYTES = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PAT_W-1:0]  pat,
`ifdef PATCNT_MASK_EN
    input  logic [PAT_W-1:0]  pat_mask,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       cnt_within,
    output logic [15:0]       cnt_bytes,
    output logic [15:0]       cnt_cross
);

    localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);
    localparam logic [8:0]        c_last_idx = 9'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [8:0]         r_idx;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_busy;
    logic               r_done;
    logic               r_drain_2nd;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_mask;

    // Read-data stage: byte on mem_rdata is valid, first byte has no predecessor
    logic               r_rd_valid;
    logic               r_rd_first;
    logic [PAT_W-2:0]   r_prev;

    // Per-byte results waiting to be added into the totals
    logic               r_s2_valid;
    logic [3:0]         r_s2_win;
    logic [3:0]         r_s2_bnd;
    logic               r_s2_hit;

    logic [15:0]        r_cnt_within;
    logic [15:0]        r_cnt_bytes;
    logic [15:0]        r_cnt_cross;

    logic               w_accept;
    logic [PAT_W+6:0]   w_cat;
    logic [3:0]         w_win;
    logic [3:0]         w_bnd;

    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cat      = {r_prev, mem_rdata};

    assign mem_addr   = r_addr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cnt_within = r_cnt_within;
    assign cnt_bytes  = r_cnt_bytes;
    assign cnt_cross  = r_cnt_cross;

    function automatic logic f_match(input logic [PAT_W-1:0] win,
                                     input logic [PAT_W-1:0] p,
                                     input logic [PAT_W-1:0] m);
        return ((win ^ p) & m) == '0;
    endfunction

    // Scan the byte currently on mem_rdata: inside-byte windows, then the
    // windows that straddle the boundary with the previous byte.
    always_comb begin
        w_win = '0;
        w_bnd = '0;
        for (int k = 0; k <= 8 - PAT_W; k++) begin
            if (f_match(mem_rdata[k +: PAT_W], r_pat, r_mask))
                w_win = w_win + 4'd1;
        end
        for (int k = 9 - PAT_W; k <= 7; k++) begin
            if (!r_rd_first && f_match(w_cat[k +: PAT_W], r_pat, r_mask))
                w_bnd = w_bnd + 4'd1;
        end
    end

    // Control FSM: address sequencing, two-cycle drain, registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_addr      <= c_base;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_drain_2nd <= 1'b0;
            r_pat       <= '0;
            r_mask      <= '1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_idx   <= '0;
                        r_addr  <= c_base;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pat   <= pat;
`ifdef PATCNT_MASK_EN
                        r_mask  <= pat_mask;
`else
                        r_mask  <= '1;
`endif
                    end
                end
                S_FETCH: begin
                    if (r_idx == c_last_idx) begin
                        r_state     <= S_DRAIN;
                        r_drain_2nd <= 1'b0;
                    end else begin
                        r_idx  <= r_idx + 9'd1;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // First cycle scans the last byte, second folds it into totals
                    if (r_drain_2nd) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_2nd <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: track returned bytes, register per-byte results, accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid   <= 1'b0;
            r_rd_first   <= 1'b0;
            r_prev       <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_win     <= '0;
            r_s2_bnd     <= '0;
            r_s2_hit     <= 1'b0;
            r_cnt_within <= '0;
            r_cnt_bytes  <= '0;
            r_cnt_cross  <= '0;
        end else begin
            r_rd_valid <= (r_state == S_FETCH);
            r_rd_first <= (r_state == S_FETCH) && (r_idx == 9'd0);
            if (r_rd_valid)
                r_prev <= mem_rdata[PAT_W-2:0];

            r_s2_valid <= r_rd_valid;
            r_s2_win   <= w_win;
            r_s2_bnd   <= w_bnd;
            r_s2_hit   <= (w_win != 4'd0);

            if (w_accept) begin
                r_cnt_within <= '0;
                r_cnt_bytes  <= '0;
                r_cnt_cross  <= '0;
            end else if (r_s2_valid) begin
                r_cnt_within <= r_cnt_within + 16'(r_s2_win);
                r_cnt_bytes  <= r_cnt_bytes + 16'(r_s2_hit);
                r_cnt_cross  <= r_cnt_cross + 16'(r_s2_win) + 16'(r_s2_bnd);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pattern_counter
//  Purpose  : Self-checking bench for pattern_counter (PAT_W=5, NUM_BYTES=32)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_counter;

    localparam int PW = 5;
    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pat = '0;
    logic [PW-1:0] pat_mask = '1;
    logic [7:0]    mem_addr;
    logic [7:0]    mem_rdata = '0;
    logic          busy, done;
    logic [15:0]   cnt_within, cnt_bytes, cnt_cross;

    logic [7:0]    mem [0:255];

    typedef struct {
        int w;
        int b;
        int c;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    pattern_counter #(.PAT_W(PW), .NUM_BYTES(NB), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pat        (pat),
`ifdef PATCNT_MASK_EN
        .pat_mask   (pat_mask),
`endif
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .cnt_within (cnt_within),
        .cnt_bytes  (cnt_bytes),
        .cnt_cross  (cnt_cross)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for an address appears one cycle later
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: count windows straight from the bit string definition
    function automatic exp_t model(input logic [PW-1:0] p, input logic [PW-1:0] m);
        exp_t e;
        int   bits [0:NB*8-1];
        e.w = 0; e.b = 0; e.c = 0;
        for (int i = 0; i < NB; i++) begin
            int hits = 0;
            for (int j = 0; j < 8; j++) bits[i*8+j] = (mem[i] >> (7 - j)) & 1;
            for (int k = 0; k <= 8 - PW; k++) begin
                int v = (mem[i] >> k) & ((1 << PW) - 1);
                if (((v ^ p) & m) == 0) hits++;
            end
            e.w += hits;
            if (hits > 0) e.b++;
        end
        for (int s = 0; s <= NB*8 - PW; s++) begin
            int v = 0;
            for (int j = 0; j < PW; j++) v = (v << 1) | bits[s+j];
            if (((v ^ p) & m) == 0) e.c++;
        end
        return e;
    endfunction

    // Scoreboard monitor: every rising done consumes one expectation
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cnt_within", int'(cnt_within), e.w);
                chk("cnt_bytes",  int'(cnt_bytes),  e.b);
                chk("cnt_cross",  int'(cnt_cross),  e.c);
            end
        end
        done_q = done;
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // One search; optionally pulses start mid-FETCH to show it is ignored
    task automatic run(input logic [PW-1:0] p, input logic [PW-1:0] m,
                       input exp_t e, input bit ign);
        int n;
        @(negedge clk);
        pat = p; pat_mask = m; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_cleared", int'(done), 0);
        n = 0;
        while (n <= 100) begin
            @(posedge clk); #1;
            n++;
            if (ign && n == 5) begin start = 1'b1; pat = ~p; pat_mask = '0; end
            if (ign && n == 6) begin start = 1'b0; pat = p; pat_mask = m; end
            if (done) break;
        end
        chk("done_latency", n, NB + 2);
        chk("busy_at_done", int'(busy), 0);
        chk("addr_hold", int'(mem_addr), NB - 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", int'(done), 1);
    endtask

    initial begin
        exp_t e;
        fill(8'h00);
        #17;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cross", int'(cnt_cross), 0);
        chk("rst_addr", int'(mem_addr), 0);
        @(negedge clk); rst_n = 1'b1;

        // All-zero data, zero pattern
        e = '{128, 32, 252};
        run(5'b00000, 5'b11111, e, 1'b0);
        // Alternating bits
        fill(8'h55);
        e = '{64, 32, 126};
        run(5'b10101, 5'b11111, e, 1'b0);
        // No matches anywhere
        fill(8'hFF);
        e = '{0, 0, 0};
        run(5'b00000, 5'b11111, e, 1'b0);
        // Only a boundary-straddling match
        fill(8'h00);
        mem[0] = 8'h07;
        e = '{0, 0, 1};
        run(5'b11100, 5'b11111, e, 1'b0);

        // Reset in the middle of FETCH, then a clean restart
        fill(8'h00);
        @(negedge clk);
        pat = '0; pat_mask = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("pre_reset_cnt_nonzero", int'(cnt_within != 16'd0), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_within", int'(cnt_within), 0);
        chk("midrst_bytes", int'(cnt_bytes), 0);
        chk("midrst_cross", int'(cnt_cross), 0);
        chk("midrst_addr", int'(mem_addr), 0);
        @(negedge clk); rst_n = 1'b1;
        e = '{128, 32, 252};
        run(5'b00000, 5'b11111, e, 1'b1);

`ifdef PATCNT_MASK_EN
        // Fully masked pattern matches every window
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
        e = '{128, 32, 252};
        run(5'b10110, 5'b00000, e, 1'b0);
`endif

        // Randomized searches against the reference model
        for (int t = 0; t < 10; t++) begin
            logic [PW-1:0] p, m;
            for (int i = 0; i < NB; i++) begin
                // Sparse data in some runs so zero-heavy patterns hit often
                if (t % 2 == 0) mem[i] = 8'($urandom);
                else            mem[i] = 8'($urandom) & 8'($urandom);
            end
            p = PW'($urandom);
`ifdef PATCNT_MASK_EN
            m = PW'($urandom);
`else
            m = '1;
`endif
            e = model(p, m);
            run(p, m, e, (t == 3));
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL pending_results actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_counter.md
PATTERN_COUNTER -- requirements
Module: pattern_counter

Interface
REQ-001 Parameter PAT_W, default 5, pattern width in bits, legal range 2..8.
REQ-002 Parameter NUM_BYTES, default 32, length of the search string in bytes, legal range 1..256.
REQ-003 Parameter ADDR_W, default 8, data-memory address width.
REQ-004 Parameter BASE_ADDR, default 0, data-memory address of string byte 0.
REQ-005 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port: start  input  1  request to begin a search; sampled on the rising edge.
REQ-008 Port: pat  input  PAT_W  search pattern; latched when start is accepted.
REQ-009 Port: mem_addr  output  ADDR_W  data-memory read address.
REQ-010 Port: mem_rdata  input  8  read data, valid one cycle after mem_addr is presented.
REQ-011 Port: busy  output  1  high while a search is in progress.
REQ-012 Port: done  output  1  high when results are valid; held until the next accepted start or reset.
REQ-013 Port: cnt_within  output  16  matches fully contained in a single byte.
REQ-014 Port: cnt_bytes  output  16  bytes containing at least one within-byte match.
REQ-015 Port: cnt_cross  output  16  matches anywhere in the bit string, byte boundaries included.

Function
REQ-016 The block SHALL use states IDLE, FETCH, DRAIN and DONE.
REQ-017 IDLE or DONE with start=1 SHALL latch pat, clear all counts, drop done and move to FETCH on that edge.
REQ-018 FETCH SHALL present mem_addr = BASE_ADDR + i for i = 0..NUM_BYTES-1 on consecutive cycles, then move to DRAIN.
REQ-019 The byte returned for address i SHALL be scanned in the cycle after that address is presented; DRAIN scans the last byte, then moves to DONE.
REQ-020 done SHALL rise on the (NUM_BYTES+2)th rising edge after the edge that accepted start, with all three counts final.
REQ-021 busy SHALL be high exactly in FETCH and DRAIN.
REQ-022 start during FETCH or DRAIN SHALL be ignored.
REQ-023 Within-byte windows SHALL be byte bits [PAT_W-1+k:k] for k = 0..8-PAT_W; each matching window adds 1 to cnt_within.
REQ-024 cnt_bytes SHALL increment by 1 per byte with at least one within-byte match.
REQ-025 The bit string SHALL be byte 0 bit 7 first, through byte NUM_BYTES-1 bit 0; cnt_cross SHALL count all NUM_BYTES*8-PAT_W+1 windows of it, overlapping matches counted separately.
REQ-026 Cross-boundary windows SHALL combine the low PAT_W-1 bits of the previous byte with the current byte; byte 0 SHALL contribute no cross-boundary windows.
REQ-027 Counts SHALL be zero-extended to 16 bits and never wrap within the parameter ranges.
REQ-028 mem_addr SHALL hold its last value outside FETCH.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, done=0, all counts 0 and mem_addr=BASE_ADDR, including mid-search.
REQ-030 After rst_n rises, the first start SHALL begin a complete new search.

Configuration
REQ-031 With macro PATCNT_MASK_EN defined, the block SHALL add input pat_mask (width PAT_W), latched with pat; a window matches when ((window XOR pat) AND pat_mask) == 0.
REQ-032 Without PATCNT_MASK_EN, port pat_mask SHALL be absent and matching SHALL be exact equality.

Verification (PAT_W=5, NUM_BYTES=32, mask macro undefined unless stated)
REQ-033 All bytes 0x00, pat=00000 -> cnt_within=128, cnt_bytes=32, cnt_cross=252, done on edge 34.
REQ-034 All bytes 0x55, pat=10101 -> cnt_within=64, cnt_bytes=32, cnt_cross=126.
REQ-035 All bytes 0xFF, pat=00000 -> all counts 0.
REQ-036 Byte 0 = 0x07, rest 0x00, pat=11100 -> cnt_within=0, cnt_bytes=0, cnt_cross=1.
REQ-037 Pulse rst_n low during FETCH, then restart with all bytes 0x00, pat=00000 -> outputs 0 during reset, then 128/32/252; a second start pulse mid-FETCH is ignored.
REQ-038 PATCNT_MASK_EN defined, pat_mask=00000, any data -> cnt_within=128, cnt_bytes=32, cnt_cross=252.
